mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: cycles dm_req_o may wait for dm_gnt_i before abort.
REQ-002 SHALL have port clk  in  1  single clock, rising edge.
REQ-003 SHALL have port arst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ex_out_i  in  ex_stage_out_t  EX result: rd, opr_b, opr_res, pc4, lsuop, rf_en, dm_en, wb_sel.
REQ-005 SHALL have port ex_valid_i  in  1  ex_out_i valid.
REQ-006 SHALL have port mem_ready_o  out  1  stage can accept; low stalls EX.
REQ-007 SHALL have ports dm_req_o out 1, dm_we_o out 1, dm_addr_o out 32, dm_wdata_o out 32, dm_be_o out 4: data-memory request.
REQ-008 SHALL have ports dm_gnt_i in 1, dm_rdata_i in 32: access complete; rdata valid with gnt.
REQ-009 SHALL have ports wb_valid_o out 1, wb_rf_en_o out 1, wb_rd_o out 5, wb_opr_res_o out 32, wb_lsu_rdata_o out 32, wb_pc4_o out 32, wb_sel_o out 2: registered WB bundle.
REQ-010 SHALL have port fwd_o  out  ex_stage_in_frm_mem_t  forwarding to EX.
REQ-011 SHALL have ports bus_err_o out 1 and misalign_o out 1: one-cycle fault pulses.

Function
REQ-012 SHALL implement FSM IDLE, REQ; mem_ready_o = (state==IDLE).
REQ-013 In IDLE, ex_valid_i=1 SHALL capture ex_out_i at next edge; dm_en=0 -> wb bundle loaded at that same edge (latency 1), state stays IDLE.
REQ-014 dm_en=1 SHALL go to REQ; dm_req_o=1 from next cycle, address/data/be/we held stable until completion.
REQ-015 dm_addr_o SHALL equal opr_res; dm_we_o=1 for SB/SH/SW.
REQ-016 dm_be_o: SB 1<<addr[1:0]; SH 4'b0011 (addr[1]=0) or 4'b1100; SW 4'b1111; loads 4'b1111.
REQ-017 dm_wdata_o: SB byte replicated x4, SH halfword replicated x2, SW opr_b.
REQ-018 In REQ, dm_gnt_i=1 SHALL complete: wb bundle loaded next edge, loads extract lane by addr[1:0] with LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; state -> IDLE; dm_req_o low next cycle.
REQ-019 Wait counter SHALL count REQ cycles without gnt; at count==MAX_WAIT: abort, bus_err_o=1 one cycle, wb_valid_o=1 with wb_rf_en_o=0, state -> IDLE, counter cleared.
REQ-020 gnt on the same cycle count reaches MAX_WAIT SHALL count as success (no bus_err_o).
REQ-021 wb_valid_o SHALL be one-cycle per instruction; no new instruction accepted while in REQ.
REQ-022 fwd_o SHALL reflect instruction held in wb bundle: rf_en = wb_valid_o & wb_rf_en_o & not-load, rd = wb_rd_o, opr_res = wb_opr_res_o.
REQ-023 Stores SHALL write wb_rf_en_o=0 regardless of ex_out_i.rf_en.

Reset
REQ-024 arst_n low SHALL immediately force state IDLE, counter 0, dm_req_o/dm_we_o/dm_be_o/wb_valid_o/wb_rf_en_o/bus_err_o/misalign_o/fwd_o.rf_en to 0, all data outputs 0, mem_ready_o 1.
REQ-025 Reset during REQ SHALL drop dm_req_o in same cycle and discard the pending instruction; late dm_gnt_i after reset SHALL be ignored.

Configuration
REQ-026 With MEM_STAGE_MISALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 issues no request, misalign_o=1 one cycle, wb_valid_o=1 with wb_rf_en_o=0, latency 1.
REQ-027 Without it: misalign_o tied 0, dm_addr_o low bits forced to access alignment, access proceeds normally.

Verification
REQ-028 ALU op rd=5 opr_res=0x1234, valid -> next cycle wb_valid_o=1, wb_rd_o=5, wb_opr_res_o=0x1234, dm_req_o never 1.
REQ-029 LB addr 0x103, gnt after 2 cycles, rdata 0x80FFFFFF -> wb_lsu_rdata_o=0xFFFFFF80, mem_ready_o low 3 cycles.
REQ-030 SH addr 0x202 opr_b 0xABCD -> dm_be_o=4'b1100, dm_wdata_o=0xABCDABCD, dm_we_o=1, wb_rf_en_o=0.
REQ-031 LW, dm_gnt_i never asserted, MAX_WAIT=15 -> bus_err_o pulse after 15 REQ cycles, wb_rf_en_o=0, mem_ready_o returns 1.
REQ-032 arst_n low during REQ then gnt arrives -> dm_req_o 0 immediately, no wb_valid_o.
REQ-033 Macro defined, LW addr 0x102 -> misalign_o=1, dm_req_o stays 0; undefined -> dm_addr_o=0x100.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: issues data-memory requests for loads/stores, waits for grant
// with a bounded timeout, and registers the write-back bundle.
// Optional build macro: MEM_STAGE_MISALIGN_CHECK_EN (trap misaligned halfword/word
// accesses instead of silently aligning the address).

package mem_stage_pkg;
  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_LBU = 3'd3,
    LSU_LHU = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsuop_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] opr_b;
    logic [31:0] opr_res;
    logic [31:0] pc4;
    lsuop_e      lsuop;
    logic        rf_en;
    logic        dm_en;
    logic [1:0]  wb_sel;
  } ex_stage_out_t;

  typedef struct packed {
    logic        rf_en;
    logic [4:0]  rd;
    logic [31:0] opr_res;
  } ex_stage_in_frm_mem_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15  // must be >= 1
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  ex_stage_out_t        ex_out_i,
  input  logic                 ex_valid_i,
  output logic                 mem_ready_o,
  output logic                 dm_req_o,
  output logic                 dm_we_o,
  output logic [31:0]          dm_addr_o,
  output logic [31:0]          dm_wdata_o,
  output logic [3:0]           dm_be_o,
  input  logic                 dm_gnt_i,
  input  logic [31:0]          dm_rdata_i,
  output logic                 wb_valid_o,
  output logic                 wb_rf_en_o,
  output logic [4:0]           wb_rd_o,
  output logic [31:0]          wb_opr_res_o,
  output logic [31:0]          wb_lsu_rdata_o,
  output logic [31:0]          wb_pc4_o,
  output logic [1:0]           wb_sel_o,
  output ex_stage_in_frm_mem_t fwd_o,
  output logic                 bus_err_o,
  output logic                 misalign_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

  state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic        w_timeout;

  // pending instruction while the request is outstanding
  lsuop_e      r_lsuop;
  logic        r_rf_en;
  logic [4:0]  r_rd;
  logic [31:0] r_opr_res;
  logic [31:0] r_pc4;
  logic [1:0]  r_wb_sel;
  logic        r_wb_is_load;

  logic        w_is_store, w_is_half, w_is_word, w_misal, w_pend_store;
  logic [31:0] w_addr, w_wdata, w_ld_data;
  logic [3:0]  w_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // request formation from the incoming EX result
  always_comb begin
    w_is_store = ex_out_i.lsuop inside {LSU_SB, LSU_SH, LSU_SW};
    w_is_half  = ex_out_i.lsuop inside {LSU_LH, LSU_LHU, LSU_SH};
    w_is_word  = ex_out_i.lsuop inside {LSU_LW, LSU_SW};
    w_addr     = ex_out_i.opr_res;
    w_misal    = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    w_misal    = (w_is_half & w_addr[0]) | (w_is_word & (w_addr[1:0] != 2'b00));
`else
    if (w_is_half) w_addr[0]   = 1'b0;
    if (w_is_word) w_addr[1:0] = 2'b00;
`endif
    w_be    = 4'b1111;
    w_wdata = ex_out_i.opr_b;
    case (ex_out_i.lsuop)
      LSU_SB: begin
        w_be    = 4'(4'b0001 << w_addr[1:0]);
        w_wdata = {4{ex_out_i.opr_b[7:0]}};
      end
      LSU_SH: begin
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ex_out_i.opr_b[15:0]}};
      end
      default: ;
    endcase
  end

  // load lane extraction from the granted read data
  always_comb begin
    case (dm_addr_o[1:0])
      2'd0:    w_byte = dm_rdata_i[7:0];
      2'd1:    w_byte = dm_rdata_i[15:8];
      2'd2:    w_byte = dm_rdata_i[23:16];
      default: w_byte = dm_rdata_i[31:24];
    endcase
    w_half = dm_addr_o[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
    case (r_lsuop)
      LSU_LB:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      LSU_LBU: w_ld_data = {24'd0, w_byte};
      LSU_LH:  w_ld_data = {{16{w_half[15]}}, w_half};
      LSU_LHU: w_ld_data = {16'd0, w_half};
      LSU_LW:  w_ld_data = dm_rdata_i;
      default: w_ld_data = 32'd0;
    endcase
    w_pend_store = r_lsuop inside {LSU_SB, LSU_SH, LSU_SW};
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = ~dm_gnt_i & (w_cnt_inc == CNT_W'(MAX_WAIT));

  // state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (ex_valid_i && ex_out_i.dm_en && !w_misal) w_state_nxt = S_REQ;
      S_REQ:   if (dm_gnt_i || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    mem_ready_o = 1'b0;
    if (r_state == S_IDLE) mem_ready_o = 1'b1;
  end

  // request, wait counter and write-back bundle registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt          <= '0;
      dm_req_o       <= 1'b0;
      dm_we_o        <= 1'b0;
      dm_addr_o      <= 32'd0;
      dm_wdata_o     <= 32'd0;
      dm_be_o        <= 4'd0;
      r_lsuop        <= LSU_LB;
      r_rf_en        <= 1'b0;
      r_rd           <= 5'd0;
      r_opr_res      <= 32'd0;
      r_pc4          <= 32'd0;
      r_wb_sel       <= 2'd0;
      r_wb_is_load   <= 1'b0;
      wb_valid_o     <= 1'b0;
      wb_rf_en_o     <= 1'b0;
      wb_rd_o        <= 5'd0;
      wb_opr_res_o   <= 32'd0;
      wb_lsu_rdata_o <= 32'd0;
      wb_pc4_o       <= 32'd0;
      wb_sel_o       <= 2'd0;
      bus_err_o      <= 1'b0;
      misalign_o     <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      bus_err_o  <= 1'b0;
      misalign_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid_i) begin
            if (!ex_out_i.dm_en || w_misal) begin
              // retire without a memory access
              wb_valid_o     <= 1'b1;
              wb_rf_en_o     <= ex_out_i.rf_en & ~ex_out_i.dm_en;
              wb_rd_o        <= ex_out_i.rd;
              wb_opr_res_o   <= ex_out_i.opr_res;
              wb_lsu_rdata_o <= 32'd0;
              wb_pc4_o       <= ex_out_i.pc4;
              wb_sel_o       <= ex_out_i.wb_sel;
              r_wb_is_load   <= 1'b0;
              misalign_o     <= w_misal;
            end else begin
              dm_req_o   <= 1'b1;
              dm_we_o    <= w_is_store;
              dm_addr_o  <= w_addr;
              dm_wdata_o <= w_wdata;
              dm_be_o    <= w_be;
              r_lsuop    <= ex_out_i.lsuop;
              r_rf_en    <= ex_out_i.rf_en;
              r_rd       <= ex_out_i.rd;
              r_opr_res  <= ex_out_i.opr_res;
              r_pc4      <= ex_out_i.pc4;
              r_wb_sel   <= ex_out_i.wb_sel;
              r_cnt      <= '0;
            end
          end
        end
        S_REQ: begin
          if (dm_gnt_i || w_timeout) begin
            dm_req_o       <= 1'b0;
            dm_we_o        <= 1'b0;
            dm_be_o        <= 4'd0;
            r_cnt          <= '0;
            wb_valid_o     <= 1'b1;
            wb_rd_o        <= r_rd;
            wb_opr_res_o   <= r_opr_res;
            wb_pc4_o       <= r_pc4;
            wb_sel_o       <= r_wb_sel;
            wb_rf_en_o     <= dm_gnt_i & r_rf_en & ~w_pend_store;
            wb_lsu_rdata_o <= dm_gnt_i ? w_ld_data : 32'd0;
            r_wb_is_load   <= ~w_pend_store;
            bus_err_o      <= ~dm_gnt_i;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // forwarding of the retired instruction (loads never forward from here)
  assign fwd_o.rf_en   = wb_valid_o & wb_rf_en_o & ~r_wb_is_load;
  assign fwd_o.rd      = wb_rd_o;
  assign fwd_o.opr_res = wb_opr_res_o;

endmodule
